// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   NREQ / SEL_W : requester count and select width
//   state_e      : arbiter FSM states
//   onehot4()    : select index -> one-hot grant vector
package mux4_arb_pkg;
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4      = '0;
    onehot4[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   start : index scanned first; scan order start, start+1, ... mod 4
//   valid : any request present
//   idx   : index of the first requester found
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);
  // Rotate so bit 0 of rot is the requester at 'start'; then a fixed
  // lowest-bit-first priority gives the round-robin scan.
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] rot;
  logic [SEL_W-1:0]  off;

  assign dbl = {req, req};
  assign rot = dbl >> start;

  always_comb begin
    off = '0;
    casez (rot[NREQ-1:0])
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign valid = |req;
  assign idx   = start + off;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data-mux output channel among four
// requesters, holding each grant for up to BURST accepted beats.
//   clk, rst          : clock, synchronous active-high reset
//   req[3:0]          : per-requester request (bit i <-> din_i)
//   din0..din3        : requester data
//   gnt, sel          : registered one-hot grant / mux select
//   out_valid/out_data/out_last/out_ready : downstream valid/ready channel
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [WIDTH-1:0]  din0,
  input  logic [WIDTH-1:0]  din1,
  input  logic [WIDTH-1:0]  din2,
  input  logic [WIDTH-1:0]  din3,
  output logic [NREQ-1:0]   gnt,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready
);
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_e                      state, state_d;
  logic [SEL_W-1:0]            sel_d, ptr, ptr_d, pick_start, pick_idx, sel_inc;
  logic [NREQ-1:0]             gnt_d;
  logic [3:0]                  beat_cnt, cnt_d;
  logic                        pick_vld, busy, xfer, rel;
  logic [NREQ-1:0][WIDTH-1:0]  din_arr;

  assign din_arr  = {din3, din2, din1, din0};
  assign out_data = din_arr[sel];

  assign busy      = (state == BUSY);
  assign out_valid = busy & req[sel];
  assign out_last  = out_valid & (beat_cnt == LAST_BEAT);
  assign xfer      = out_valid & out_ready;
  // Release on the final beat of the burst, or when the owner withdraws.
  assign rel       = busy & ((xfer & (beat_cnt == LAST_BEAT)) | ~req[sel]);

  // One picker serves both the idle pick (scan from ptr) and the
  // release-time pick (scan from owner+1, so the owner comes last).
  assign sel_inc    = sel + 2'd1;
  assign pick_start = busy ? sel_inc : ptr;

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state;
    sel_d   = sel;
    gnt_d   = gnt;
    ptr_d   = ptr;
    cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          gnt_d   = onehot4(pick_idx);
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_d = sel_inc;
          cnt_d = '0;
          if (pick_vld) begin
            sel_d = pick_idx;
            gnt_d = onehot4(pick_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (xfer) begin
          cnt_d = beat_cnt + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      gnt      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      gnt      <= gnt_d;
      ptr      <= ptr_d;
      beat_cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] din [4];
  logic         out_ready;

  logic [3:0]   gnt4, gnt2;
  logic [1:0]   sel4, sel2;
  logic         vld4, vld2, lst4, lst2;
  logic [W-1:0] dat4, dat2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(W), .BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .gnt(gnt4), .sel(sel4), .out_valid(vld4), .out_data(dat4),
    .out_last(lst4), .out_ready(out_ready)
  );

  mux4_rr_arbiter #(.WIDTH(W), .BURST(2)) dut2 (
    .clk(clk), .rst(rst), .req(req),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .gnt(gnt2), .sel(sel2), .out_valid(vld2), .out_data(dat2),
    .out_last(lst2), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic       lst;
    logic [3:0] cnt;
    logic [1:0] ptr;
  } vec_t;

  vec_t tbl [33];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] rq, logic rd, logic [3:0] g, logic [1:0] s,
                              logic v, logic l, logic [3:0] c, logic [1:0] p);
    vec_t r;
    r.req = rq; r.rdy = rd; r.gnt = g; r.sel = s;
    r.vld = v;  r.lst = l;  r.cnt = c; r.ptr = p;
    return r;
  endfunction

  task automatic rand_din();
    for (int k = 0; k < 4; k++) din[k] = W'($urandom);
  endtask

  // Compare dut4 outputs against one expected record.
  task automatic chk4(input string tag, input vec_t e);
    chk({tag, " gnt"},  32'(gnt4), 32'(e.gnt));
    chk({tag, " sel"},  32'(sel4), 32'(e.sel));
    chk({tag, " vld"},  32'(vld4), 32'(e.vld));
    chk({tag, " last"}, 32'(lst4), 32'(e.lst));
    chk({tag, " data"}, 32'(dat4), 32'(din[e.sel]));
    chk({tag, " cnt"},  32'(dut4.beat_cnt), 32'(e.cnt));
    chk({tag, " ptr"},  32'(dut4.ptr), 32'(e.ptr));
  endtask

  task automatic chk2(input string tag, input vec_t e);
    chk({tag, " gnt"},  32'(gnt2), 32'(e.gnt));
    chk({tag, " sel"},  32'(sel2), 32'(e.sel));
    chk({tag, " vld"},  32'(vld2), 32'(e.vld));
    chk({tag, " last"}, 32'(lst2), 32'(e.lst));
    chk({tag, " data"}, 32'(dat2), 32'(din[e.sel]));
    chk({tag, " cnt"},  32'(dut2.beat_cnt), 32'(e.cnt));
    chk({tag, " ptr"},  32'(dut2.ptr), 32'(e.ptr));
  endtask

  initial begin
    // ---- vector table (dut4, BURST=4), outputs seen during each cycle ----
    tbl[0] = mk(4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0);
    for (int o = 0; o < 4; o++)
      for (int b = 0; b < 4; b++)
        tbl[1 + o*4 + b] = mk(4'b1111, 1, 4'(1 << o), 2'(o), 1, (b == 3), 4'(b), 2'(o));
    tbl[17] = mk(4'b1111, 1, 4'b0001, 0, 1, 0, 1 - 1, 0);
    tbl[18] = mk(4'b1110, 1, 4'b0001, 0, 0, 0, 1, 0);   // owner 0 withdraws
    tbl[19] = mk(4'b1111, 1, 4'b0010, 1, 1, 0, 0, 1);
    tbl[20] = mk(4'b1101, 1, 4'b0010, 1, 0, 0, 1, 1);   // owner 1 withdraws
    tbl[21] = mk(4'b1100, 1, 4'b0100, 2, 1, 0, 0, 2);   // owner 2 beat 1
    tbl[22] = mk(4'b1000, 1, 4'b0100, 2, 0, 0, 1, 2);   // owner 2 withdraws
    tbl[23] = mk(4'b1000, 1, 4'b1000, 3, 1, 0, 0, 3);   // handover, cnt=0
    for (int k = 24; k < 29; k++)                       // 5 stall cycles
      tbl[k] = mk(4'b1000, 0, 4'b1000, 3, 1, 0, 1, 3);
    tbl[29] = mk(4'b1000, 1, 4'b1000, 3, 1, 0, 1, 3);
    tbl[30] = mk(4'b1000, 1, 4'b1000, 3, 1, 0, 2, 3);
    tbl[31] = mk(4'b1000, 1, 4'b1000, 3, 1, 1, 3, 3);
    tbl[32] = mk(4'b1000, 0, 4'b1000, 3, 1, 0, 0, 0);   // lone regrant

    // ---- reset with all requests asserted ----
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    rand_din();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk4("reset", mk(4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0));
    chk("reset dut2 gnt", 32'(gnt2), 32'h0);

    // ---- table-driven run ----
    rst = 1'b0;
    for (int i = 0; i < 33; i++) begin
      req = tbl[i].req; out_ready = tbl[i].rdy;
      rand_din();
      #1;
      chk4($sformatf("row%0d", i), tbl[i]);
      @(negedge clk);
    end

    // ---- lone requester 1, BURST=2 (dut2) ----
    rst = 1'b1; req = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t seq [6];
      seq[0] = mk(4'b0010, 1, 4'b0000, 0, 0, 0, 0, 0);
      seq[1] = mk(4'b0010, 1, 4'b0010, 1, 1, 0, 0, 0);
      seq[2] = mk(4'b0010, 1, 4'b0010, 1, 1, 1, 1, 0);
      seq[3] = mk(4'b0010, 1, 4'b0010, 1, 1, 0, 0, 2);
      seq[4] = mk(4'b0010, 1, 4'b0010, 1, 1, 1, 1, 2);
      seq[5] = mk(4'b0010, 1, 4'b0010, 1, 1, 0, 0, 2);
      for (int i = 0; i < 6; i++) begin
        rand_din();
        #1;
        chk2($sformatf("lone%0d", i), seq[i]);
        @(negedge clk);
      end
    end

    // ---- reset mid-burst on owner 3 (dut4) ----
    rst = 1'b1; req = 4'b1000; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1; chk4("mid idle", mk(4'b1000, 1, 4'b0000, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1; chk4("mid beat1", mk(4'b1000, 1, 4'b1000, 3, 1, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    #1; chk4("mid beat2", mk(4'b1000, 1, 4'b1000, 3, 1, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0; req = 4'b1001;
    #1; chk4("mid after rst", mk(4'b1001, 1, 4'b0000, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1; chk4("mid regrant", mk(4'b1001, 1, 4'b0001, 0, 1, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares a single 4:1 data-mux output channel among four requesters. It grants one requester at a time and holds the grant for a burst of up to BURST accepted beats. While a grant is held, it drives the mux select and presents the winner's data on a valid/ready output channel. It sits between four producer ports and one downstream consumer.

## Interface
- WIDTH, 8: data width of each input and of the output.
- BURST, 4: maximum accepted beats per grant; legal range 1..15.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  per-requester request; bit i belongs to din_i
- din0..din3  in  WIDTH each  requester data
- gnt  out  4  one-hot registered grant; all-zero when idle
- sel  out  2  registered mux select = index of granted requester
- out_valid  out  1  req[sel] & busy (combinational from registered state)
- out_data  out  WIDTH  din[sel], always driven
- out_last  out  1  out_valid & (beat_cnt == BURST-1)
- out_ready  in  1  consumer accepts the beat when out_valid is high

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, BUSY. Internal registers: state, owner (= sel), ptr (2 bits, rotating priority start), beat_cnt (4 bits).
- Pick function: the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
- IDLE: if req != 0, on the next edge set owner = pick, gnt = onehot(owner), beat_cnt = 0, and go to BUSY. Otherwise stay in IDLE with gnt = 0.
- BUSY, transfer: when out_valid & out_ready, beat_cnt increments.
- BUSY, release: the grant is released at the edge where either:
  - a transfer occurs with beat_cnt == BURST-1, or
  - req[owner] == 0 (the requester withdrew, with no transfer that cycle).
- On release:
  - ptr = owner+1 mod 4.
  - Re-arbitrate in the same edge using the current req, with scan start owner+1.
  - If a winner exists, the new grant takes effect next cycle with beat_cnt = 0 and no bubble. Otherwise go to IDLE.
- The released owner may be regranted immediately only if no other requester is pending.
- Requester protocol: a beat is consumed from requester i when gnt[i] & req[i] & out_ready. The requester holds din stable until that happens.
- Dropping req before the burst completes ends the grant early. This is not an error.
- BURST=1: every accepted beat releases the grant, giving strict per-beat round robin.

## Timing
- Reset values:
  - state = IDLE, gnt = 0, sel = 0, ptr = 0, beat_cnt = 0
  - out_valid = 0, out_last = 0, out_data = din0
- Grant latency: req rising before edge N produces gnt and out_valid after edge N (one cycle).
- Throughput: one beat per cycle while out_ready=1. Handover between owners costs zero cycles.
- out_ready low stalls the transfer. The grant and beat_cnt hold, and there is no timeout.
- Simultaneous events:
  - Release by burst completion and a new request from another port in the same cycle: the new request participates in that edge's pick.
  - rst has priority over all events, mid-burst included. No beat is counted on a reset edge.
- Only out_valid, out_data and out_last are combinational from inputs: req[sel], din and registered state. gnt and sel are glitch-free registers.

## Structure
- Shared package mux4_arb_pkg holds:
  - localparam NREQ=4 and SEL_W=2
  - the state enum {IDLE, BUSY}
  - a function onehot4(idx)
- Sub-module rr_pick4 is combinational. It takes req[3:0] and start[1:0] and returns valid and idx[1:0]. It is instantiated once, for both the IDLE pick and the release-time pick.
- The data path is a WIDTH-wide 4:1 selection on sel.

## Test plan
- Reset and idle: hold rst 2 cycles with req=4'b1111 → gnt=0, out_valid=0, sel=0. After release, the first grant is gnt=4'b0001.
- Round robin: req=4'b1111 constant, out_ready=1, BURST=4 → grants 0,1,2,3,0 in turn, each lasting exactly 4 beats, out_last on every 4th beat, no idle cycles between owners.
- Early withdrawal: owner 2 drops req after 1 beat while req[3] is high → next cycle gnt=4'b1000 and beat_cnt=0.
- Backpressure: hold out_ready=0 for 5 cycles mid-burst → gnt, sel and beat_cnt are unchanged and out_data stays din[sel]. Resuming completes the remaining beats.
- Lone requester: only req[1]=1, BURST=2 → requester 1 is regranted back-to-back with no IDLE cycle, and ptr ends at 2.
- Reset mid-burst: assert rst during beat 2 of owner 3 → gnt=0 next cycle, ptr=0. The next arbitration with req=4'b1001 grants 0.
